bus_gate_arbiter: RTL and testbench

BUS_GATE_ARBITER -- requirements
Module: bus_gate_arbiter

---
 rtl/bus_gate_arbiter.sv | 109 ++++++++++
 tb/tb_bus_gate_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/bus_gate_arbiter.sv
// Two-requester bus arbiter with burst limit, round-robin tie-break and grant-gated data mux.
// Optional even parity output PAR is built only when BUS_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | no grant, bus driven to zero
// G0     | requester 0 owns the bus
// G1     | requester 1 owns the bus
module bus_gate_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic [15:0] D0,
   input  logic [15:0] D1,
   output logic        GNT0,
   output logic        GNT1,
   output logic [15:0] Y,
   output logic        VLD
`ifdef BUS_PARITY_EN
   ,
   output logic        PAR
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_G0   = 2'd1;
   localparam logic [1:0] S_G1   = 2'd2;
   localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

   logic [1:0] state, state_nxt;
   logic       last, last_nxt;
   logic [3:0] cnt, cnt_nxt;

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            // On a tie, the requester that was not granted last goes first.
            if (REQ0 && (!REQ1 || last)) begin
               state_nxt = S_G0;
               cnt_nxt   = 4'd1;
               last_nxt  = 1'b0;
            end else if (REQ1) begin
               state_nxt = S_G1;
               cnt_nxt   = 4'd1;
               last_nxt  = 1'b1;
            end
         end
         S_G0: begin
            if (!REQ0 || (cnt >= BURST_MAX && REQ1)) begin
               if (REQ1) begin
                  state_nxt = S_G1;
                  cnt_nxt   = 4'd1;
                  last_nxt  = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
                  cnt_nxt   = 4'd0;
               end
            end else if (cnt < BURST_MAX) begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         S_G1: begin
            if (!REQ1 || (cnt >= BURST_MAX && REQ0)) begin
               if (REQ0) begin
                  state_nxt = S_G0;
                  cnt_nxt   = 4'd1;
                  last_nxt  = 1'b0;
               end else begin
                  state_nxt = S_IDLE;
                  cnt_nxt   = 4'd0;
               end
            end else if (cnt < BURST_MAX) begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_IDLE;
         last  <= 1'b1;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign GNT0 = (state == S_G0);
   assign GNT1 = (state == S_G1);
   assign VLD  = GNT0 | GNT1;
   assign Y    = (D0 & {16{GNT0}}) | (D1 & {16{GNT1}});

`ifdef BUS_PARITY_EN
   assign PAR = ^Y;
`endif

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed-vector bench for bus_gate_arbiter (MAX_BURST = 4).
module tb_bus_gate_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        REQ0, REQ1;
   logic [15:0] D0, D1;
   logic        GNT0, GNT1, VLD;
   logic [15:0] Y;
`ifdef BUS_PARITY_EN
   logic        PAR;
`endif

   int n_vec = 0;
   int n_err = 0;

   bus_gate_arbiter #(.MAX_BURST(4)) dut (
      .CLK  (CLK),
      .RST  (RST),
      .REQ0 (REQ0),
      .REQ1 (REQ1),
      .D0   (D0),
      .D1   (D1),
      .GNT0 (GNT0),
      .GNT1 (GNT1),
      .Y    (Y),
      .VLD  (VLD)
`ifdef BUS_PARITY_EN
      ,
      .PAR  (PAR)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // e0/e1 are the expected grants; the expected bus value is given explicitly.
   task automatic expect_bus(input string tag, input logic e0, input logic e1, input logic [15:0] ey);
      chk({tag, ".gnt0"}, 32'(GNT0), 32'(e0));
      chk({tag, ".gnt1"}, 32'(GNT1), 32'(e1));
      chk({tag, ".vld"},  32'(VLD),  32'(e0 | e1));
      chk({tag, ".y"},    32'(Y),    32'(ey));
`ifdef BUS_PARITY_EN
      chk({tag, ".par"},  32'(PAR),  32'(^ey));
`endif
   endtask

   initial begin
      RST = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1; D0 = 16'h5678; D1 = 16'h1111;
      step(); step();
      expect_bus("reset_prio", 1'b0, 1'b0, 16'h0000);

      // Single requester 0
      RST = 1'b0; REQ1 = 1'b0;
      step();
      expect_bus("req0_only", 1'b1, 1'b0, 16'h5678);
      REQ0 = 1'b0;
      step();
      expect_bus("req0_release", 1'b0, 1'b0, 16'h0000);

      // LAST = 0 now, so a tie from IDLE goes to requester 1
      REQ0 = 1'b1; REQ1 = 1'b1; D1 = 16'h2222;
      step();
      expect_bus("tie_after_g0", 1'b0, 1'b1, 16'h2222);

      // Reset restores LAST = 1: tie goes to requester 0, then 4-cycle bursts alternate
      RST = 1'b1; step();
      expect_bus("reset_mid_g1", 1'b0, 1'b0, 16'h0000);
      RST = 1'b0; D0 = 16'h00FF; D1 = 16'hAB00;
      for (int i = 0; i < 4; i++) begin
         step();
         expect_bus($sformatf("burst_g0_%0d", i), 1'b1, 1'b0, 16'h00FF);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         expect_bus($sformatf("burst_g1_%0d", i), 1'b0, 1'b1, 16'hAB00);
      end
      step();
      expect_bus("burst_back_g0", 1'b1, 1'b0, 16'h00FF);

      // Zero-idle handover when requester 0 drops
      REQ0 = 1'b0;
      step();
      expect_bus("handover", 1'b0, 1'b1, 16'hAB00);

      // Requester 1 alone keeps the bus past MAX_BURST
      for (int i = 0; i < 10; i++) begin
         step();
         expect_bus($sformatf("g1_hold_%0d", i), 1'b0, 1'b1, 16'hAB00);
      end

      // Reset pulse during G1, then tie goes to requester 0
      RST = 1'b1; REQ0 = 1'b1;
      step();
      expect_bus("rst_in_g1", 1'b0, 1'b0, 16'h0000);
      RST = 1'b0;
      step();
      expect_bus("tie_after_rst", 1'b1, 1'b0, 16'h00FF);

      // Idle bus must be zero even with all-ones data; grants never overlap
      RST = 1'b1; step(); RST = 1'b0;
      REQ0 = 1'b0; REQ1 = 1'b0; D0 = 16'hFFFF; D1 = 16'h1234;
      step();
      expect_bus("idle_mask", 1'b0, 1'b0, 16'h0000);
      REQ0 = 1'b1; REQ1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("excl_%0d", i), 32'(GNT0 & GNT1), 32'd0);
         if (i < 4) expect_bus($sformatf("mask_g0_%0d", i), 1'b1, 1'b0, 16'hFFFF);
         else       expect_bus($sformatf("mask_g1_%0d", i), 1'b0, 1'b1, 16'h1234);
      end
      REQ0 = 1'b0; REQ1 = 1'b0;
      step();
      expect_bus("final_idle", 1'b0, 1'b0, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
